// File: rtl/ac_match_engine_if.sv
// ac_match_engine_if
// Bundles the symbol stream handshake and the table configuration bus of
// ac_match_engine.
//   in_valid / in_sym / in_ready : one symbol moves on in_valid && in_ready
//   cfg_we    : table write strobe (honoured only while the engine is disabled)
//   cfg_sel   : 0 = goto, 1 = failure, 2 = output, 3 = reserved
//   cfg_addr  : goto uses {state, sym}; failure/output use the low STATE_W bits
//   cfg_data  : goto {valid, next}; failure {next}; output {flag, id}
// master = the side feeding symbols and tables, slave = the engine.
interface ac_match_engine_if #(
  parameter int CHAR_W  = 4,
  parameter int STATE_W = 8,
  parameter int ID_W    = 4
);
  logic                      in_valid;
  logic [CHAR_W-1:0]         in_sym;
  logic                      in_ready;
  logic                      cfg_we;
  logic [1:0]                cfg_sel;
  logic [STATE_W+CHAR_W-1:0] cfg_addr;
  logic [STATE_W+ID_W:0]     cfg_data;

  modport master (
    output in_valid, in_sym, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sym, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready
  );
endinterface

// File: rtl/ac_match_engine.sv
// ac_match_engine
// Table-loadable Aho-Corasick matcher. Goto, failure and output tables live in
// internal register arrays; one symbol is consumed per accepted handshake and
// a goto miss from a non-root state triggers a failure walk during which the
// input is stalled.
//   clk, rst     : clock, synchronous active-high reset (also clears tables)
//   en           : 1 = run, 0 = freeze and allow table writes
//   initialize   : one-cycle pulse, back to root, position/count/error cleared
//   bus (slave)  : symbol handshake + configuration bus
//   match        : one-cycle pulse, with match_id and match_pos
//   match_count  : saturating number of matches
//   state        : current automaton state
//   busy         : high while a failure walk is in progress
//   err          : sticky failure-walk overrun
module ac_match_engine #(
  parameter int CHAR_W  = 4,
  parameter int STATE_W = 8,
  parameter int ID_W    = 4,
  parameter int POS_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               initialize,
  ac_match_engine_if.slave   bus,
  output logic               match,
  output logic [ID_W-1:0]    match_id,
  output logic [POS_W-1:0]   match_pos,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               err
);
  localparam int NUM_STATES = 1 << STATE_W;
  localparam int NUM_EDGES  = 1 << (STATE_W + CHAR_W);
  // A walk overruns on the failure step that would bring the counter to 2^STATE_W.
  localparam logic [STATE_W:0] WALK_LAST = {1'b0, {STATE_W{1'b1}}};

  typedef enum logic {RUN, WALK} fsm_t;

  logic               goto_valid [NUM_EDGES];
  logic [STATE_W-1:0] goto_next  [NUM_EDGES];
  logic [STATE_W-1:0] fail_state [NUM_STATES];
  logic               out_flag   [NUM_STATES];
  logic [ID_W-1:0]    out_id     [NUM_STATES];

  fsm_t                fsm;
  logic [CHAR_W-1:0]   sym_r;
  logic [STATE_W:0]    walk_cnt;
  logic [POS_W-1:0]    pos;

  logic [CHAR_W-1:0]         look_sym;
  logic [STATE_W+CHAR_W-1:0] look_addr;
  logic                      hit;
  logic [STATE_W-1:0]        hit_next;
  logic                      hit_match;
  logic [POS_W-1:0]          sym_pos;
  logic                      active;
  logic                      cfg_unused;

  assign bus.in_ready = en && (fsm == RUN) && !initialize && !rst;
  assign busy         = (fsm == WALK);

  // During a walk the latched symbol is looked up from the walking state; in
  // RUN the live input symbol is used. POS has already advanced past a walking
  // symbol, so its own position is one behind the counter.
  assign look_sym  = (fsm == WALK) ? sym_r : bus.in_sym;
  assign look_addr = {state, look_sym};
  assign hit       = goto_valid[look_addr];
  assign hit_next  = goto_next[look_addr];
  assign hit_match = out_flag[hit_next] && (hit_next != '0);
  assign sym_pos   = (fsm == WALK) ? pos - 1'b1 : pos;
  assign active    = (fsm == WALK) ? en : (bus.in_ready && bus.in_valid);

  // The data word is wider than any single table field; fold it so that the
  // bits no field uses are still consumed.
  assign cfg_unused = ^bus.cfg_data;

  // Control parts of the tables: valid bits, failure links and output flags
  // are cleared by reset so a freshly reset engine never matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_EDGES; i++) goto_valid[i] <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) begin
        fail_state[i] <= '0;
        out_flag[i]   <= 1'b0;
      end
    end else if (bus.cfg_we && !en) begin
      case (bus.cfg_sel)
        2'd0:    goto_valid[bus.cfg_addr] <= bus.cfg_data[STATE_W];
        2'd1:    fail_state[bus.cfg_addr[STATE_W-1:0]] <= bus.cfg_data[STATE_W-1:0];
        2'd2:    out_flag[bus.cfg_addr[STATE_W-1:0]] <= bus.cfg_data[ID_W];
        default: ;
      endcase
    end
  end

  // Payload parts of the tables are only meaningful behind a valid bit or
  // output flag, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.cfg_we && !en) begin
      if (bus.cfg_sel == 2'd0) goto_next[bus.cfg_addr] <= bus.cfg_data[STATE_W-1:0];
      if (bus.cfg_sel == 2'd2) out_id[bus.cfg_addr[STATE_W-1:0]] <= bus.cfg_data[ID_W-1:0];
    end
  end

  // Matcher FSM. A hit (from RUN or WALK) lands on the next state and reports
  // a match; a miss at the root simply stays there; any other miss follows the
  // failure link and keeps walking until a hit, the root, or the overrun bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= RUN;
      state       <= '0;
      sym_r       <= '0;
      walk_cnt    <= '0;
      pos         <= '0;
      match       <= 1'b0;
      match_id    <= '0;
      match_pos   <= '0;
      match_count <= '0;
      err         <= 1'b0;
    end else if (initialize) begin
      fsm         <= RUN;
      state       <= '0;
      walk_cnt    <= '0;
      pos         <= '0;
      match       <= 1'b0;
      match_count <= '0;
      err         <= 1'b0;
    end else begin
      match <= 1'b0;
      if (active) begin
        if (fsm == RUN) begin
          pos   <= pos + 1'b1;
          sym_r <= bus.in_sym;
        end
        if (hit) begin
          state <= hit_next;
          fsm   <= RUN;
          if (hit_match) begin
            match     <= 1'b1;
            match_id  <= out_id[hit_next];
            match_pos <= sym_pos;
            if (match_count != '1) match_count <= match_count + 1'b1;
          end
        end else if (state == '0) begin
          fsm <= RUN;
        end else if ((fsm == WALK) && (walk_cnt == WALK_LAST)) begin
          err   <= 1'b1;
          state <= '0;
          fsm   <= RUN;
        end else begin
          state    <= fail_state[state];
          walk_cnt <= (fsm == RUN) ? {{STATE_W{1'b0}}, 1'b1} : walk_cnt + 1'b1;
          fsm      <= WALK;
        end
      end
    end
  end
endmodule

// File: tb/tb_ac_match_engine.sv
// tb_ac_match_engine
// Self-checking bench for ac_match_engine. Instance A uses the default widths
// and the {he, she, his, hers} dictionary; instance B (STATE_W=3, POS_W=2,
// CNT_W=2) covers position wrap, count saturation and the walk overrun.
// Random streams on A are compared with a behavioural Aho-Corasick model.
module tb_ac_match_engine;
  localparam int SYM_H = 1, SYM_E = 2, SYM_S = 3, SYM_I = 4, SYM_R = 5, SYM_U = 6;

  typedef struct {
    int sym;
    int exp_match;
    int exp_id;
    int exp_pos;
    int exp_state;
    int exp_stall;
  } vec_t;

  typedef struct {
    int state;
    int match;
    int id;
    int pos;
    int count;
    int busy;
    int err;
    int ready;
  } obs_t;

  logic clk;
  logic rst;
  logic en;
  logic initialize;

  logic        match_a, busy_a, err_a;
  logic [3:0]  match_id_a;
  logic [15:0] match_pos_a, match_count_a;
  logic [7:0]  state_a;

  logic        match_b, busy_b, err_b;
  logic [3:0]  match_id_b;
  logic [1:0]  match_pos_b, match_count_b;
  logic [2:0]  state_b;

  int vectors;
  int miscompares;

  // Reference tables for instance A, filled only by legitimate loads.
  int m_next [256][16];
  int m_fail [256];
  int m_flag [256];
  int m_id   [256];

  ac_match_engine_if #(.CHAR_W(4), .STATE_W(8), .ID_W(4)) ifa ();
  ac_match_engine_if #(.CHAR_W(4), .STATE_W(3), .ID_W(4)) ifb ();

  ac_match_engine #(.CHAR_W(4), .STATE_W(8), .ID_W(4), .POS_W(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .initialize(initialize), .bus(ifa),
    .match(match_a), .match_id(match_id_a), .match_pos(match_pos_a),
    .match_count(match_count_a), .state(state_a), .busy(busy_a), .err(err_a)
  );

  ac_match_engine #(.CHAR_W(4), .STATE_W(3), .ID_W(4), .POS_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .initialize(initialize), .bus(ifb),
    .match(match_b), .match_id(match_id_b), .match_pos(match_pos_b),
    .match_count(match_count_b), .state(state_b), .busy(busy_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic obs_t observe(input bit use_b);
    obs_t o;
    if (use_b) begin
      o.state = int'(state_b);  o.match = int'(match_b);   o.id = int'(match_id_b);
      o.pos = int'(match_pos_b); o.count = int'(match_count_b); o.busy = int'(busy_b);
      o.err = int'(err_b);      o.ready = int'(ifb.in_ready);
    end else begin
      o.state = int'(state_a);  o.match = int'(match_a);   o.id = int'(match_id_a);
      o.pos = int'(match_pos_a); o.count = int'(match_count_a); o.busy = int'(busy_a);
      o.err = int'(err_a);      o.ready = int'(ifa.in_ready);
    end
    return o;
  endfunction

  // Behavioural Aho-Corasick step: follow failure links until an edge exists
  // or the root is reached; each failure link followed costs one stall cycle.
  function automatic void model_step(input int s, input int sym, output int ns, output int steps);
    int cur;
    cur   = s;
    steps = 0;
    ns    = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      if (m_next[cur][sym] >= 0) begin
        ns = m_next[cur][sym];
        return;
      end
      if (cur == 0) return;
      cur = m_fail[cur];
      steps++;
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cfg_write(input bit use_b, input int sel, input int addr, input int data);
    @(negedge clk);
    if (use_b) begin
      ifb.cfg_we = 1'b1; ifb.cfg_sel = 2'(sel); ifb.cfg_addr = 7'(addr); ifb.cfg_data = 8'(data);
    end else begin
      ifa.cfg_we = 1'b1; ifa.cfg_sel = 2'(sel); ifa.cfg_addr = 12'(addr); ifa.cfg_data = 13'(data);
    end
    @(negedge clk);
    ifa.cfg_we = 1'b0;
    ifb.cfg_we = 1'b0;
  endtask

  task automatic set_goto(input bit use_b, input int s, input int c, input int n);
    cfg_write(use_b, 0, s * 16 + c, use_b ? (8 | n) : (256 | n));
    if (!use_b) m_next[s][c] = n;
  endtask

  task automatic set_fail(input bit use_b, input int s, input int f);
    cfg_write(use_b, 1, s, f);
    if (!use_b) m_fail[s] = f;
  endtask

  task automatic set_out(input bit use_b, input int s, input int id);
    cfg_write(use_b, 2, s, 16 | id);
    if (!use_b) begin
      m_flag[s] = 1;
      m_id[s]   = id;
    end
  endtask

  task automatic pulse_init();
    @(negedge clk);
    initialize = 1'b1;
    @(negedge clk);
    initialize = 1'b0;
  endtask

  // Present a symbol and return right after the edge that accepted it.
  task automatic accept_only(input bit use_b, input int sym);
    obs_t o;
    int   n;
    @(negedge clk);
    if (use_b) begin ifb.in_valid = 1'b1; ifb.in_sym = 4'(sym); end
    else       begin ifa.in_valid = 1'b1; ifa.in_sym = 4'(sym); end
    #1;
    n = 0;
    o = observe(use_b);
    while (o.ready == 0 && n < 100) begin
      @(negedge clk);
      n++;
      o = observe(use_b);
    end
    if (n >= 100) checkOutput("ready_timeout", o.ready, 1);
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  // Present a symbol and wait until its walk (if any) is over; stall returns
  // the number of cycles the engine spent walking.
  task automatic applyStimulus(input bit use_b, input int sym, output int stall);
    obs_t o;
    accept_only(use_b, sym);
    stall = 0;
    @(negedge clk);
    o = observe(use_b);
    while (o.busy != 0 && stall < 600) begin
      stall++;
      @(negedge clk);
      o = observe(use_b);
    end
    if (stall >= 600) checkOutput("settle_timeout", stall, 0);
  endtask

  initial begin
    vec_t ushers [6];
    obs_t o;
    int   stall, ns, steps, exp_match, m_state, m_pos, m_cnt, sym, k;

    // "ushers": u miss at root, s-h-e reaches she, r walks once to her, s reaches hers
    ushers[0] = '{SYM_U, 0, 0, 0, 0, 0};
    ushers[1] = '{SYM_S, 0, 0, 0, 3, 0};
    ushers[2] = '{SYM_H, 0, 0, 0, 4, 0};
    ushers[3] = '{SYM_E, 1, 1, 3, 5, 0};
    ushers[4] = '{SYM_R, 0, 0, 0, 8, 1};
    ushers[5] = '{SYM_S, 1, 3, 5, 9, 0};

    vectors = 0;
    miscompares = 0;
    for (int s = 0; s < 256; s++) begin
      for (int c = 0; c < 16; c++) m_next[s][c] = -1;
      m_fail[s] = 0; m_flag[s] = 0; m_id[s] = 0;
    end

    rst = 1'b1; en = 1'b0; initialize = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_sym = '0; ifa.cfg_we = 1'b0; ifa.cfg_sel = '0; ifa.cfg_addr = '0; ifa.cfg_data = '0;
    ifb.in_valid = 1'b0; ifb.in_sym = '0; ifb.cfg_we = 1'b0; ifb.cfg_sel = '0; ifb.cfg_addr = '0; ifb.cfg_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    en = 1'b1;
    #1;
    checkOutput("ready_in_reset", observe(0).ready, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    o = observe(0);
    checkOutput("rst.state", o.state, 0);
    checkOutput("rst.match", o.match, 0);
    checkOutput("rst.count", o.count, 0);
    checkOutput("rst.busy", o.busy, 0);
    checkOutput("rst.err", o.err, 0);
    checkOutput("rst.ready_en0", o.ready, 0);
    en = 1'b1;
    #1;
    checkOutput("rst.ready_en1", observe(0).ready, 1);

    // Dictionary tables
    en = 1'b0;
    set_goto(0, 0, SYM_H, 1); set_goto(0, 1, SYM_E, 2); set_goto(0, 0, SYM_S, 3);
    set_goto(0, 3, SYM_H, 4); set_goto(0, 4, SYM_E, 5); set_goto(0, 1, SYM_I, 6);
    set_goto(0, 6, SYM_S, 7); set_goto(0, 2, SYM_R, 8); set_goto(0, 8, SYM_S, 9);
    set_fail(0, 5, 2); set_fail(0, 4, 1); set_fail(0, 7, 3); set_fail(0, 9, 3);
    set_out(0, 2, 0); set_out(0, 5, 1); set_out(0, 7, 2); set_out(0, 9, 3);
    set_goto(1, 0, SYM_H, 1); set_goto(1, 1, SYM_E, 2); set_fail(1, 1, 1); set_out(1, 2, 0);
    en = 1'b1;

    $display("[TB] ushers stream");
    pulse_init();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, ushers[i].sym, stall);
      o = observe(0);
      checkOutput("ushers.stall", stall, ushers[i].exp_stall);
      checkOutput("ushers.state", o.state, ushers[i].exp_state);
      checkOutput("ushers.match", o.match, ushers[i].exp_match);
      if (ushers[i].exp_match != 0) begin
        checkOutput("ushers.id", o.id, ushers[i].exp_id);
        checkOutput("ushers.pos", o.pos, ushers[i].exp_pos);
      end
    end
    checkOutput("ushers.count", observe(0).count, 2);

    $display("[TB] config write while enabled is ignored");
    pulse_init();
    cfg_write(0, 0, SYM_H, 256 | 3);
    applyStimulus(0, SYM_H, stall);
    checkOutput("cfg_en.state_h", observe(0).state, 1);
    applyStimulus(0, SYM_E, stall);
    o = observe(0);
    checkOutput("cfg_en.match", o.match, 1);
    checkOutput("cfg_en.id", o.id, 0);
    checkOutput("cfg_en.pos", o.pos, 1);

    $display("[TB] initialize during walk");
    pulse_init();
    applyStimulus(0, SYM_S, stall);
    applyStimulus(0, SYM_H, stall);
    applyStimulus(0, SYM_E, stall);
    checkOutput("init.pre_count", observe(0).count, 1);
    accept_only(0, SYM_R);
    @(negedge clk);
    checkOutput("init.walking", observe(0).busy, 1);
    initialize = 1'b1;
    @(negedge clk);
    initialize = 1'b0;
    #1;
    o = observe(0);
    checkOutput("init.state", o.state, 0);
    checkOutput("init.match", o.match, 0);
    checkOutput("init.busy", o.busy, 0);
    checkOutput("init.count", o.count, 0);
    applyStimulus(0, SYM_H, stall);
    applyStimulus(0, SYM_E, stall);
    o = observe(0);
    checkOutput("init.he_match", o.match, 1);
    checkOutput("init.he_pos", o.pos, 1);
    checkOutput("init.he_count", o.count, 1);

    $display("[TB] enable dropped mid-walk");
    pulse_init();
    applyStimulus(0, SYM_S, stall);
    applyStimulus(0, SYM_H, stall);
    applyStimulus(0, SYM_E, stall);
    accept_only(0, SYM_R);
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      o = observe(0);
      checkOutput("freeze.state", o.state, 2);
      checkOutput("freeze.busy", o.busy, 1);
    end
    en = 1'b1;
    @(negedge clk);
    o = observe(0);
    checkOutput("resume.state", o.state, 8);
    checkOutput("resume.busy", o.busy, 0);
    applyStimulus(0, SYM_S, stall);
    o = observe(0);
    checkOutput("resume.match", o.match, 1);
    checkOutput("resume.id", o.id, 3);
    checkOutput("resume.pos", o.pos, 4);
    checkOutput("resume.count", o.count, 2);

    $display("[TB] random stream against model");
    pulse_init();
    m_state = 0; m_pos = 0; m_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      sym = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 6));
      model_step(m_state, sym, ns, steps);
      exp_match = (ns != 0 && m_flag[ns] != 0) ? 1 : 0;
      applyStimulus(0, sym, stall);
      o = observe(0);
      checkOutput("rand.stall", stall, steps);
      checkOutput("rand.state", o.state, ns);
      checkOutput("rand.match", o.match, exp_match);
      if (exp_match != 0) begin
        if (m_cnt < 65535) m_cnt++;
        checkOutput("rand.id", o.id, m_id[ns]);
        checkOutput("rand.pos", o.pos, m_pos);
      end
      checkOutput("rand.count", o.count, m_cnt);
      m_state = ns;
      m_pos = (m_pos + 1) % 65536;
    end

    $display("[TB] position wrap and count saturation");
    pulse_init();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, (i % 2 == 0) ? SYM_H : SYM_E, stall);
      o = observe(1);
      checkOutput("wrap.match", o.match, i % 2);
      if (i % 2 == 1) begin
        k++;
        checkOutput("wrap.pos", o.pos, i % 4);
        checkOutput("wrap.count", o.count, (k < 3) ? k : 3);
      end
    end

    $display("[TB] failure walk overrun");
    pulse_init();
    applyStimulus(1, SYM_H, stall);
    checkOutput("overrun.state_h", observe(1).state, 1);
    applyStimulus(1, SYM_H, stall);
    o = observe(1);
    checkOutput("overrun.stall", stall, (1 << 3) - 1);
    checkOutput("overrun.err", o.err, 1);
    checkOutput("overrun.state", o.state, 0);
    checkOutput("overrun.ready", o.ready, 1);
    checkOutput("overrun.match", o.match, 0);
    applyStimulus(1, SYM_H, stall);
    o = observe(1);
    checkOutput("overrun.sticky", o.err, 1);
    checkOutput("overrun.recover", o.state, 1);
    pulse_init();
    checkOutput("overrun.cleared", observe(1).err, 0);

    $display("[TB] reset clears outputs and tables");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    o = observe(0);
    checkOutput("rst2.id", o.id, 0);
    checkOutput("rst2.pos", o.pos, 0);
    checkOutput("rst2.count", o.count, 0);
    applyStimulus(0, SYM_H, stall);
    checkOutput("rst2.tables_cleared", observe(0).state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
